// File: rtl/riscv_pkg.sv
`default_nettype none
// ============================================================================
// Module   : riscv_pkg
// Purpose  : Shared encodings for the RV32IM execute-stage control: ALU
//            control codes, main-decoder ALUOp codes, M-extension funct3
//            codes, multiply/divide FSM states and operand-sign helpers.
// Revision : 1.0 - initial release
// ============================================================================
package riscv_pkg;

    // ALU operation encodings driven on ALUControl
    localparam logic [3:0] c_alu_add  = 4'b0000;
    localparam logic [3:0] c_alu_sub  = 4'b0001;
    localparam logic [3:0] c_alu_and  = 4'b0010;
    localparam logic [3:0] c_alu_or   = 4'b0011;
    localparam logic [3:0] c_alu_xor  = 4'b0100;
    localparam logic [3:0] c_alu_slt  = 4'b0101;
    localparam logic [3:0] c_alu_sll  = 4'b0110;
    localparam logic [3:0] c_alu_srl  = 4'b0111;
    localparam logic [3:0] c_alu_sra  = 4'b1000;
    localparam logic [3:0] c_alu_sltu = 4'b1101;
    localparam logic [3:0] c_alu_md   = 4'b1111;

    // ALUOp codes from the main decoder
    localparam logic [1:0] c_aluop_add   = 2'b00;
    localparam logic [1:0] c_aluop_sub   = 2'b01;
    localparam logic [1:0] c_aluop_rtype = 2'b10;

    // M-extension funct3 codes
    localparam logic [2:0] c_f3_mul    = 3'b000;
    localparam logic [2:0] c_f3_mulh   = 3'b001;
    localparam logic [2:0] c_f3_mulhsu = 3'b010;
    localparam logic [2:0] c_f3_mulhu  = 3'b011;
    localparam logic [2:0] c_f3_div    = 3'b100;
    localparam logic [2:0] c_f3_divu   = 3'b101;
    localparam logic [2:0] c_f3_rem    = 3'b110;
    localparam logic [2:0] c_f3_remu   = 3'b111;

    // Multiply/divide engine states
    localparam logic [1:0] c_st_idle = 2'b00;
    localparam logic [1:0] c_st_mul  = 2'b01;
    localparam logic [1:0] c_st_div  = 2'b10;
    localparam logic [1:0] c_st_done = 2'b11;

    // rs1 is interpreted as signed for these ops. mul is included: the low
    // half of the product is identical either way, so one path serves both.
    function automatic logic f3_a_signed(input logic [2:0] f3);
        return (f3 == c_f3_mul)    || (f3 == c_f3_mulh) ||
               (f3 == c_f3_mulhsu) || (f3 == c_f3_div)  ||
               (f3 == c_f3_rem);
    endfunction

    // rs2 is interpreted as signed for these ops (mulhsu keeps rs2 unsigned)
    function automatic logic f3_b_signed(input logic [2:0] f3);
        return (f3 == c_f3_mul) || (f3 == c_f3_mulh) ||
               (f3 == c_f3_div) || (f3 == c_f3_rem);
    endfunction

endpackage
`default_nettype wire

// File: rtl/muldiv_iter.sv
`default_nettype none
// ============================================================================
// Module   : muldiv_iter
// Purpose  : One-bit-per-cycle unsigned datapath shared by multiply
//            (shift-add into a {hi,lo} accumulator) and restoring divide
//            (hi = partial remainder, lo = dividend shifting into quotient).
//            Exposes the post-step values so the final step's result can be
//            captured on the same edge that completes it.
// Revision : 1.0 - initial release
// ============================================================================
module muldiv_iter #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            load,
    input  logic            step,
    input  logic            is_div,
    input  logic [XLEN-1:0] a_mag,
    input  logic [XLEN-1:0] b_mag,
    output logic [XLEN-1:0] hi_next,
    output logic [XLEN-1:0] lo_next,
    output logic            done
);

    localparam int c_cnt_w = $clog2(XLEN);

    logic [XLEN-1:0]    r_hi;
    logic [XLEN-1:0]    r_lo;
    logic [XLEN-1:0]    r_b;
    logic [c_cnt_w-1:0] r_cnt;

    logic [XLEN:0]      w_sum;
    logic [XLEN:0]      w_shift;
    logic [XLEN:0]      w_diff;

    // Next accumulator/remainder/quotient value for one iteration
    always_comb begin
        w_sum   = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_b} : '0);
        w_shift = {r_hi, r_lo[XLEN-1]};
        w_diff  = w_shift - {1'b0, r_b};
        hi_next = w_sum[XLEN:1];
        lo_next = {w_sum[0], r_lo[XLEN-1:1]};
        if (is_div) begin
            // MSB of the difference is the borrow: set means "does not fit"
            if (!w_diff[XLEN]) begin
                hi_next = w_diff[XLEN-1:0];
                lo_next = {r_lo[XLEN-2:0], 1'b1};
            end else begin
                hi_next = w_shift[XLEN-1:0];
                lo_next = {r_lo[XLEN-2:0], 1'b0};
            end
        end
    end

    // Operand load, per-cycle step and iteration counter
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_hi  <= '0;
            r_lo  <= '0;
            r_b   <= '0;
            r_cnt <= '0;
        end else if (load) begin
            r_hi  <= '0;
            r_lo  <= a_mag;
            r_b   <= b_mag;
            r_cnt <= c_cnt_w'(XLEN - 1);
        end else if (step) begin
            r_hi <= hi_next;
            r_lo <= lo_next;
            if (r_cnt != '0) begin
                r_cnt <= r_cnt - c_cnt_w'(1);
            end
        end
    end

    assign done = (r_cnt == '0);

endmodule
`default_nettype wire

// File: rtl/alu_md_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : alu_md_ctrl
// Purpose  : RV32I ALU control decode plus M-extension multiply/divide
//            sequencer. Decodes ALUControl, detects M ops, runs the
//            iterative engine (or a single-cycle fast path) and stalls the
//            pipeline until the sign-corrected result is presented.
// Revision : 1.0 - initial release
// ============================================================================
module alu_md_ctrl
    import riscv_pkg::*;
#(
    parameter int XLEN     = 32,
    parameter bit FAST_MUL = 1'b0
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            opb5,
    input  logic [2:0]      funct3,
    input  logic            funct7b5,
    input  logic            funct7b0,
    input  logic [1:0]      ALUOp,
    input  logic            start,
    input  logic            flush,
    input  logic [XLEN-1:0] srcA,
    input  logic [XLEN-1:0] srcB,
    output logic [3:0]      ALUControl,
    output logic            md_sel,
    output logic            stall,
    output logic [XLEN-1:0] md_result,
    output logic            md_valid,
    output logic            busy
);

    localparam logic [XLEN-1:0] c_int_min = {1'b1, {(XLEN-1){1'b0}}};

    logic [1:0]        r_state;
    logic [1:0]        w_state_next;
    logic [XLEN-1:0]   r_md_result;
    logic              r_md_valid;
    logic              r_busy;
    logic              r_neg_res;
    logic              r_neg_rem;
    logic              r_sel_hi;

    logic              w_md_sel;
    logic [3:0]        w_alu_ctrl;
    logic              w_accept;
    logic              w_div_op;
    logic              w_a_neg;
    logic              w_b_neg;
    logic [XLEN-1:0]   w_a_mag;
    logic [XLEN-1:0]   w_b_mag;
    logic              w_div_zero;
    logic              w_ovf;
    logic              w_fast;
    logic              w_sel_hi;
    logic [2*XLEN-1:0] w_fast_prod;
    logic [XLEN-1:0]   w_fast_res;
    logic [XLEN-1:0]   w_hi_nx;
    logic [XLEN-1:0]   w_lo_nx;
    logic              w_iter_done;
    logic [2*XLEN-1:0] w_prod_fix;
    logic [XLEN-1:0]   w_quot_fix;
    logic [XLEN-1:0]   w_rem_fix;
    logic [XLEN-1:0]   w_iter_res;

    assign w_md_sel = (ALUOp == c_aluop_rtype) & opb5 & funct7b0;

    // ALU control decode; M ops override with the dedicated code
    always_comb begin
        w_alu_ctrl = c_alu_add;
        if (w_md_sel) begin
            w_alu_ctrl = c_alu_md;
        end else if (ALUOp == c_aluop_add) begin
            w_alu_ctrl = c_alu_add;
        end else if (ALUOp == c_aluop_sub) begin
            w_alu_ctrl = c_alu_sub;
        end else begin
            case (funct3)
                3'b000:  w_alu_ctrl = (funct7b5 & opb5) ? c_alu_sub : c_alu_add;
                3'b001:  w_alu_ctrl = c_alu_sll;
                3'b010:  w_alu_ctrl = c_alu_slt;
                3'b011:  w_alu_ctrl = c_alu_sltu;
                3'b100:  w_alu_ctrl = c_alu_xor;
                3'b101:  w_alu_ctrl = funct7b5 ? c_alu_sra : c_alu_srl;
                3'b110:  w_alu_ctrl = c_alu_or;
                default: w_alu_ctrl = c_alu_and;
            endcase
        end
    end

    // Operand sign handling and special-case detection for the accept cycle
    assign w_div_op   = funct3[2];
    assign w_a_neg    = f3_a_signed(funct3) & srcA[XLEN-1];
    assign w_b_neg    = f3_b_signed(funct3) & srcB[XLEN-1];
    assign w_a_mag    = w_a_neg ? -srcA : srcA;
    assign w_b_mag    = w_b_neg ? -srcB : srcB;
    assign w_div_zero = w_div_op & (srcB == '0);
    assign w_ovf      = w_div_op & ~funct3[0] & (srcA == c_int_min) & (srcB == '1);
    assign w_fast     = w_div_op ? (w_div_zero | w_ovf) : FAST_MUL;
    // Multiply: take the high half for mulh*; divide: take the remainder
    assign w_sel_hi   = w_div_op ? funct3[1] : (funct3[1:0] != 2'b00);
    assign w_accept   = (r_state == c_st_idle) & start & w_md_sel & ~flush;

    generate
        if (FAST_MUL) begin : g_fast_mul
            logic [2*XLEN-1:0] w_mag_prod;
            assign w_mag_prod  = {{XLEN{1'b0}}, w_a_mag} * {{XLEN{1'b0}}, w_b_mag};
            assign w_fast_prod = (w_a_neg ^ w_b_neg) ? -w_mag_prod : w_mag_prod;
        end else begin : g_iter_mul
            assign w_fast_prod = '0;
        end
    endgenerate

    // Result for ops finishing straight out of the accept cycle
    always_comb begin
        w_fast_res = w_sel_hi ? w_fast_prod[2*XLEN-1:XLEN] : w_fast_prod[XLEN-1:0];
        if (w_div_zero) begin
            w_fast_res = w_sel_hi ? srcA : '1;
        end else if (w_ovf) begin
            w_fast_res = w_sel_hi ? '0 : srcA;
        end
    end

    muldiv_iter #(
        .XLEN    (XLEN)
    ) u_iter (
        .clk     (clk),
        .reset_n (reset_n),
        .load    (w_accept),
        .step    ((r_state == c_st_mul) || (r_state == c_st_div)),
        .is_div  (r_state == c_st_div),
        .a_mag   (w_a_mag),
        .b_mag   (w_b_mag),
        .hi_next (w_hi_nx),
        .lo_next (w_lo_nx),
        .done    (w_iter_done)
    );

    // Sign fixup of the iterative result as of the final step
    always_comb begin
        w_prod_fix = r_neg_res ? -{w_hi_nx, w_lo_nx} : {w_hi_nx, w_lo_nx};
        w_quot_fix = r_neg_res ? -w_lo_nx : w_lo_nx;
        w_rem_fix  = r_neg_rem ? -w_hi_nx : w_hi_nx;
        if (r_state == c_st_div) begin
            w_iter_res = r_sel_hi ? w_rem_fix : w_quot_fix;
        end else begin
            w_iter_res = r_sel_hi ? w_prod_fix[2*XLEN-1:XLEN] : w_prod_fix[XLEN-1:0];
        end
    end

    // Engine next-state; flush returns to IDLE from anywhere
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            c_st_idle: begin
                if (w_accept) begin
                    if (w_fast) begin
                        w_state_next = c_st_done;
                    end else begin
                        w_state_next = w_div_op ? c_st_div : c_st_mul;
                    end
                end
            end
            c_st_mul, c_st_div: begin
                if (w_iter_done) begin
                    w_state_next = c_st_done;
                end
            end
            default: w_state_next = c_st_idle;
        endcase
        if (flush) begin
            w_state_next = c_st_idle;
        end
    end

    // State, status flags, latched signs and result capture into DONE
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state     <= c_st_idle;
            r_md_result <= '0;
            r_md_valid  <= 1'b0;
            r_busy      <= 1'b0;
            r_neg_res   <= 1'b0;
            r_neg_rem   <= 1'b0;
            r_sel_hi    <= 1'b0;
        end else begin
            r_state    <= w_state_next;
            r_busy     <= (w_state_next != c_st_idle);
            r_md_valid <= (w_state_next == c_st_done);
            if (w_accept) begin
                r_neg_res <= w_a_neg ^ w_b_neg;
                r_neg_rem <= w_a_neg;
                r_sel_hi  <= w_sel_hi;
            end
            if (w_state_next == c_st_done) begin
                r_md_result <= (r_state == c_st_idle) ? w_fast_res : w_iter_res;
            end
        end
    end

    assign ALUControl = w_alu_ctrl;
    assign md_sel     = w_md_sel;
    assign stall      = start & w_md_sel & (r_state != c_st_done) & reset_n & ~flush;
    assign md_result  = r_md_result;
    assign md_valid   = r_md_valid;
    assign busy       = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_alu_md_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_alu_md_ctrl
// Purpose  : Self-checking bench for alu_md_ctrl: decode table, iterative
//            and fast-path M ops through a result scoreboard, flush and
//            mid-operation reset.
// Revision : 1.0 - initial release
// ============================================================================
module tb_alu_md_ctrl;

    localparam int XLEN = 32;

    logic            clk = 1'b0;
    logic            reset_n;
    logic            opb5;
    logic [2:0]      funct3;
    logic            funct7b5;
    logic            funct7b0;
    logic [1:0]      ALUOp;
    logic            start;
    logic            flush;
    logic [XLEN-1:0] srcA;
    logic [XLEN-1:0] srcB;
    logic [3:0]      ALUControl;
    logic            md_sel;
    logic            stall;
    logic [XLEN-1:0] md_result;
    logic            md_valid;
    logic            busy;

    int              n_checks = 0;
    int              n_errors = 0;
    logic [XLEN-1:0] exp_q[$];

    alu_md_ctrl #(
        .XLEN       (XLEN),
        .FAST_MUL   (1'b0)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .opb5       (opb5),
        .funct3     (funct3),
        .funct7b5   (funct7b5),
        .funct7b0   (funct7b0),
        .ALUOp      (ALUOp),
        .start      (start),
        .flush      (flush),
        .srcA       (srcA),
        .srcB       (srcB),
        .ALUControl (ALUControl),
        .md_sel     (md_sel),
        .stall      (stall),
        .md_result  (md_result),
        .md_valid   (md_valid),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Scoreboard: every md_valid pulse must match the oldest queued result
    always @(negedge clk) begin
        if (md_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
                check("unexpected_md_valid", 64'(md_valid), 64'd0);
            end else begin
                check("md_result", 64'(md_result), 64'(exp_q.pop_front()));
            end
        end
    end

    task automatic dec_chk(input string tag, input logic [1:0] op, input logic [2:0] f3,
                           input logic f7b5, input logic ob5, input logic f7b0,
                           input logic [3:0] exp_ctl, input logic exp_sel);
        ALUOp = op; funct3 = f3; funct7b5 = f7b5; opb5 = ob5; funct7b0 = f7b0;
        #1;
        check({tag, "_ctl"}, 64'(ALUControl), 64'(exp_ctl));
        check({tag, "_sel"}, 64'(md_sel), 64'(exp_sel));
    endtask

    task automatic set_md(input logic [2:0] f3, input logic [XLEN-1:0] a, input logic [XLEN-1:0] b);
        ALUOp = 2'b10; opb5 = 1'b1; funct7b0 = 1'b1; funct7b5 = 1'b0;
        funct3 = f3; srcA = a; srcB = b; start = 1'b1;
    endtask

    // Called #1 after a rising edge; returns #1 after the edge ending DONE
    task automatic md_op(input string tag, input logic [2:0] f3, input logic [XLEN-1:0] a,
                         input logic [XLEN-1:0] b, input logic [XLEN-1:0] exp, input int exp_stall);
        int n;
        set_md(f3, a, b);
        exp_q.push_back(exp);
        n = 0;
        @(negedge clk);
        while (stall === 1'b1 && n < 100) begin
            n++;
            @(negedge clk);
        end
        check({tag, "_stall_cycles"}, 64'(n), 64'(exp_stall));
        check({tag, "_valid"}, 64'(md_valid), 64'd1);
        check({tag, "_busy"}, 64'(busy), 64'd1);
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    initial begin
        reset_n = 1'b0; start = 1'b0; flush = 1'b0;
        opb5 = 1'b0; funct3 = 3'b000; funct7b5 = 1'b0; funct7b0 = 1'b0;
        ALUOp = 2'b00; srcA = '0; srcB = '0;
        repeat (3) @(posedge clk);
        #1;
        set_md(3'b100, 32'd5, 32'd1);
        #1;
        check("rst_stall", 64'(stall), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_valid", 64'(md_valid), 64'd0);
        check("rst_result", 64'(md_result), 64'd0);
        start = 1'b0;
        reset_n = 1'b1;
        @(posedge clk); #1;

        dec_chk("add_op",   2'b00, 3'b000, 1'b0, 1'b0, 1'b0, 4'b0000, 1'b0);
        dec_chk("sub_op",   2'b01, 3'b000, 1'b0, 1'b0, 1'b0, 4'b0001, 1'b0);
        dec_chk("sub_r",    2'b10, 3'b000, 1'b1, 1'b1, 1'b0, 4'b0001, 1'b0);
        dec_chk("addi",     2'b10, 3'b000, 1'b1, 1'b0, 1'b0, 4'b0000, 1'b0);
        dec_chk("sll",      2'b10, 3'b001, 1'b0, 1'b1, 1'b0, 4'b0110, 1'b0);
        dec_chk("slt",      2'b10, 3'b010, 1'b0, 1'b1, 1'b0, 4'b0101, 1'b0);
        dec_chk("sltu",     2'b10, 3'b011, 1'b0, 1'b1, 1'b0, 4'b1101, 1'b0);
        dec_chk("xor",      2'b10, 3'b100, 1'b0, 1'b1, 1'b0, 4'b0100, 1'b0);
        dec_chk("sra",      2'b10, 3'b101, 1'b1, 1'b1, 1'b0, 4'b1000, 1'b0);
        dec_chk("srl",      2'b10, 3'b101, 1'b0, 1'b1, 1'b0, 4'b0111, 1'b0);
        dec_chk("or",       2'b10, 3'b110, 1'b0, 1'b1, 1'b0, 4'b0011, 1'b0);
        dec_chk("and",      2'b10, 3'b111, 1'b0, 1'b1, 1'b0, 4'b0010, 1'b0);
        dec_chk("md_sra",   2'b10, 3'b101, 1'b1, 1'b1, 1'b1, 4'b1111, 1'b1);
        dec_chk("aluop11",  2'b11, 3'b000, 1'b0, 1'b1, 1'b1, 4'b0000, 1'b0);
        dec_chk("imm_f7b0", 2'b10, 3'b000, 1'b0, 1'b0, 1'b1, 4'b0000, 1'b0);
        @(posedge clk); #1;

        // Back-to-back M operations
        md_op("mul",       3'b000, 32'd7,        32'hFFFFFFFD, 32'hFFFFFFEB, 33);
        md_op("mulhu",     3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 33);
        md_op("mulh",      3'b001, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 33);
        md_op("mulhsu",    3'b010, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 33);
        md_op("div_ovf",   3'b100, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1);
        md_op("rem_ovf",   3'b110, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 1);
        md_op("divu_zero", 3'b101, 32'd100,      32'd0,        32'hFFFFFFFF, 1);
        md_op("rem_zero",  3'b110, 32'hFFFFFFF9, 32'd0,        32'hFFFFFFF9, 1);
        md_op("rem_neg",   3'b110, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 33);
        md_op("div_neg",   3'b100, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, 33);
        md_op("divu",      3'b101, 32'd100,      32'd7,        32'd14,       33);
        md_op("remu",      3'b111, 32'd100,      32'd7,        32'd2,        33);
        md_op("div_min",   3'b100, 32'h80000000, 32'd2,        32'hC0000000, 33);

        // Flush at iteration 10: no result, engine idle, result held
        set_md(3'b100, 32'd1000, 32'd3);
        repeat (10) @(posedge clk);
        #1;
        check("pre_flush_busy", 64'(busy), 64'd1);
        flush = 1'b1;
        @(negedge clk);
        check("flush_stall", 64'(stall), 64'd0);
        @(posedge clk); #1;
        flush = 1'b0;
        start = 1'b0;
        @(negedge clk);
        check("flush_busy", 64'(busy), 64'd0);
        check("flush_hold", 64'(md_result), 64'hC0000000);
        repeat (40) @(posedge clk);
        #1;

        // Flush wins over start in the same cycle
        set_md(3'b000, 32'd3, 32'd4);
        flush = 1'b1;
        @(negedge clk);
        check("flush_start_stall", 64'(stall), 64'd0);
        @(posedge clk); #1;
        flush = 1'b0;
        start = 1'b0;
        @(negedge clk);
        check("flush_start_busy", 64'(busy), 64'd0);
        @(posedge clk); #1;

        // Reset in the middle of a divide discards it
        set_md(3'b101, 32'd999, 32'd5);
        repeat (5) @(posedge clk);
        #1;
        reset_n = 1'b0;
        @(negedge clk);
        check("midrst_stall", 64'(stall), 64'd0);
        @(posedge clk); #1;
        reset_n = 1'b1;
        start = 1'b0;
        @(negedge clk);
        check("midrst_busy", 64'(busy), 64'd0);
        check("midrst_valid", 64'(md_valid), 64'd0);
        check("midrst_result", 64'(md_result), 64'd0);
        repeat (40) @(posedge clk);
        #1;

        md_op("after_rst", 3'b101, 32'd100, 32'd7, 32'd14, 33);
        repeat (3) @(posedge clk);
        check("scoreboard_empty", 64'(exp_q.size()), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
